// File: rtl/alu_step_sequencer_if.sv
// Control bundle between the ALU step sequencer and the datapath it steers.
// The master drives the datapath controls. The slave supplies start/run and the IR contents.
// Purely combinational wiring, so it adds no latency and has no flow control.
interface alu_step_sequencer_if #(
    parameter int CTRL_W    = 32,
    parameter int ALU_SEL_W = 5
);
    logic                 start;
    logic                 run;
    logic [31:0]          IR_data_out;
    logic [CTRL_W-1:0]    bus_sel;
    logic [CTRL_W-1:0]    reg_enable;
    logic [ALU_SEL_W-1:0] ALU_Sel;
    logic                 IncPC;
    logic                 Read;
    logic                 busy;
    logic                 done;
    logic                 illegal;
    logic [2:0]           step;

    // Sequencer side
    modport master (
        input  start, run, IR_data_out,
        output bus_sel, reg_enable, ALU_Sel, IncPC, Read, busy, done, illegal, step
    );

    // Datapath / stimulus side
    modport slave (
        output start, run, IR_data_out,
        input  bus_sel, reg_enable, ALU_Sel, IncPC, Read, busy, done, illegal, step
    );
endinterface

// File: rtl/alu_step_sequencer.sv
// Hardwired T0-T5 control sequencer for three-register ALU instructions (fetch, decode, operate, write back).
// Latency: start at edge k gives T0 in cycle k+1 and done in cycle k+6+MEM_WAIT.
// No backpressure. start is ignored outside IDLE, and run is sampled only in T5.
module alu_step_sequencer #(
    parameter int NUM_REGS  = 16,
    parameter int CTRL_W    = 32,
    parameter int ALU_SEL_W = 5,
    parameter int ALU_IDLE  = 7,
    parameter int MEM_WAIT  = 0,
    parameter int PC_BIT    = 20,
    parameter int IR_BIT    = 21,
    parameter int MDR_BIT   = 22,
    parameter int MAR_BIT   = 23,
    parameter int Y_BIT     = 24,
    parameter int ZLO_BIT   = 19
) (
    input  logic                  Clock,
    input  logic                  clr,
    alu_step_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;

    // IR field decode. These fields are only meaningful from T3 onward.
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       unused_ir;

    assign opcode    = bus.IR_data_out[31:27];
    assign ra        = bus.IR_data_out[26:23];
    assign rb        = bus.IR_data_out[22:19];
    assign rc        = bus.IR_data_out[18:15];
    assign unused_ir = ^bus.IR_data_out[14:0];

    logic [ALU_SEL_W-1:0] alu_op;
    logic                 op_ok;
    logic                 regs_ok;
    logic                 legal;

    // Map the opcode to an ALU operation. An unmapped opcode flags the instruction illegal.
    always_comb begin
        alu_op = ALU_SEL_W'(ALU_IDLE);
        op_ok  = 1'b1;
        case (opcode)
            5'b00011: alu_op = ALU_SEL_W'(0);
            5'b00100: alu_op = ALU_SEL_W'(1);
            5'b01001: alu_op = ALU_SEL_W'(3);
            5'b01010: alu_op = ALU_SEL_W'(4);
            5'b00111: alu_op = ALU_SEL_W'(5);
            5'b01000: alu_op = ALU_SEL_W'(6);
            default:  op_ok  = 1'b0;
        endcase
    end

    assign regs_ok = ({1'b0, ra} < 5'(NUM_REGS)) &&
                     ({1'b0, rb} < 5'(NUM_REGS)) &&
                     ({1'b0, rc} < 5'(NUM_REGS));
    assign legal   = op_ok && regs_ok;

    // State and wait-counter registers. clr abandons any instruction in flight.
    always_ff @(posedge Clock or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    logic [CTRL_W-1:0]    bus_sel_c;
    logic [CTRL_W-1:0]    reg_en_c;
    logic [ALU_SEL_W-1:0] alu_sel_c;
    logic                 inc_pc_c;
    logic                 read_c;
    logic                 done_c;
    logic                 illegal_c;

    // Next-state logic and Moore output decode for each control step.
    always_comb begin
        state_nxt = state;
        wait_nxt  = '0;
        bus_sel_c = '0;
        reg_en_c  = '0;
        alu_sel_c = ALU_SEL_W'(ALU_IDLE);
        inc_pc_c  = 1'b0;
        read_c    = 1'b0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_T0;
            end
            S_T0: begin
                bus_sel_c[PC_BIT] = 1'b1;
                reg_en_c[MAR_BIT] = 1'b1;
                inc_pc_c          = 1'b1;
                state_nxt         = S_T1;
            end
            S_T1: begin
                read_c            = 1'b1;
                reg_en_c[MDR_BIT] = 1'b1;
                if (wait_cnt == 4'(MEM_WAIT)) begin
                    state_nxt = S_T2;
                end else begin
                    wait_nxt  = wait_cnt + 4'd1;
                end
            end
            S_T2: begin
                bus_sel_c[MDR_BIT] = 1'b1;
                reg_en_c[IR_BIT]   = 1'b1;
                state_nxt          = S_T3;
            end
            S_T3: begin
                // Abort before any operand moves, so nothing downstream is loaded.
                if (legal) begin
                    bus_sel_c[rb]   = 1'b1;
                    reg_en_c[Y_BIT] = 1'b1;
                    state_nxt       = S_T4;
                end else begin
                    illegal_c = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_T4: begin
                bus_sel_c[rc]     = 1'b1;
                alu_sel_c         = alu_op;
                reg_en_c[ZLO_BIT] = 1'b1;
                state_nxt         = S_T5;
            end
            S_T5: begin
                bus_sel_c[ZLO_BIT] = 1'b1;
                reg_en_c[ra]       = 1'b1;
                done_c             = 1'b1;
                state_nxt          = bus.run ? S_T0 : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.bus_sel    = bus_sel_c;
    assign bus.reg_enable = reg_en_c;
    assign bus.ALU_Sel    = alu_sel_c;
    assign bus.IncPC      = inc_pc_c;
    assign bus.Read       = read_c;
    assign bus.done       = done_c;
    assign bus.illegal    = illegal_c;
    assign bus.busy       = (state != S_IDLE);
    assign bus.step       = state;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer with three parameterisations (default, MEM_WAIT=3, NUM_REGS=8).
// Expected per-cycle control snapshots are queued when an instruction starts and compared every cycle.
// Inputs change on the falling edge, after the outputs for that cycle have been compared.
module tb_alu_step_sequencer;

    typedef struct packed {
        logic [2:0]  step;
        logic [31:0] bus_sel;
        logic [31:0] reg_enable;
        logic [4:0]  alu;
        logic        incpc;
        logic        read;
        logic        busy;
        logic        done;
        logic        illegal;
    } snap_t;

    logic        Clock;
    logic        clr;
    logic        start;
    logic        run;
    logic [31:0] ir_in;

    alu_step_sequencer_if if0 ();
    alu_step_sequencer_if if1 ();
    alu_step_sequencer_if if2 ();

    assign if0.start = start;  assign if0.run = run;  assign if0.IR_data_out = ir_in;
    assign if1.start = start;  assign if1.run = run;  assign if1.IR_data_out = ir_in;
    assign if2.start = start;  assign if2.run = run;  assign if2.IR_data_out = ir_in;

    alu_step_sequencer dut0 (.Clock(Clock), .clr(clr), .bus(if0));
    alu_step_sequencer #(.MEM_WAIT(3)) dut_w (.Clock(Clock), .clr(clr), .bus(if1));
    alu_step_sequencer #(.NUM_REGS(8)) dut_n (.Clock(Clock), .clr(clr), .bus(if2));

    snap_t o0, o1, o2;
    assign o0 = {if0.step, if0.bus_sel, if0.reg_enable, if0.ALU_Sel, if0.IncPC, if0.Read, if0.busy, if0.done, if0.illegal};
    assign o1 = {if1.step, if1.bus_sel, if1.reg_enable, if1.ALU_Sel, if1.IncPC, if1.Read, if1.busy, if1.done, if1.illegal};
    assign o2 = {if2.step, if2.bus_sel, if2.reg_enable, if2.ALU_Sel, if2.IncPC, if2.Read, if2.busy, if2.done, if2.illegal};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    sel      = 0;
    int    cycle    = 0;
    int    read_cnt = 0;
    int    ill_cnt  = 0;
    int    start_cyc;
    string tag;
    snap_t exp_q[$];
    int    done_times[$];

    function automatic snap_t sample_dut();
        case (sel)
            1:       return o1;
            2:       return o2;
            default: return o0;
        endcase
    endfunction

    function automatic snap_t mk(input logic [2:0] st, input int bs, input int re, input logic [4:0] alu,
                                 input logic inc, input logic rd, input logic dn, input logic il);
        snap_t s;
        s = '0;
        s.step = st;
        if (bs >= 0) s.bus_sel[bs] = 1'b1;
        if (re >= 0) s.reg_enable[re] = 1'b1;
        s.alu     = alu;
        s.incpc   = inc;
        s.read    = rd;
        s.busy    = (st != 3'd0);
        s.done    = dn;
        s.illegal = il;
        return s;
    endfunction

    task automatic chk_snap(input string t, input snap_t o, input snap_t e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic chk_int(input string t, input int o, input int e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", t, o, e);
        end
    endtask

    // Queue the expected control steps of one instruction, derived from the IR fields.
    task automatic push_instr(input logic [31:0] ir, input int mw, input int nregs);
        logic [4:0] op;
        int ra, rb, rc;
        logic [4:0] alu;
        logic ok;
        op = ir[31:27];
        ra = int'(ir[26:23]);
        rb = int'(ir[22:19]);
        rc = int'(ir[18:15]);
        ok = 1'b1;
        alu = 5'd7;
        case (op)
            5'b00011: alu = 5'd0;
            5'b00100: alu = 5'd1;
            5'b01001: alu = 5'd3;
            5'b01010: alu = 5'd4;
            5'b00111: alu = 5'd5;
            5'b01000: alu = 5'd6;
            default:  ok  = 1'b0;
        endcase
        if (ra >= nregs || rb >= nregs || rc >= nregs) ok = 1'b0;
        exp_q.push_back(mk(3'd1, 20, 23, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int w = 0; w <= mw; w++)
            exp_q.push_back(mk(3'd2, -1, 22, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(3'd3, 22, 21, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0));
        if (!ok) begin
            exp_q.push_back(mk(3'd4, -1, -1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
            exp_q.push_back(mk(3'd4, rb, 24, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(3'd5, rc, 19, alu, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(3'd6, 19, ra, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0));
        end
    endtask

    // Advance one cycle and compare the selected DUT against the next expected step (IDLE when queue is empty).
    task automatic cyc();
        snap_t o, e;
        @(posedge Clock);
        @(negedge Clock);
        cycle++;
        o = sample_dut();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(3'd0, -1, -1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_snap($sformatf("%s_c%0d", tag, cycle), o, e);
        if (o.done)    done_times.push_back(cycle);
        if (o.read)    read_cnt++;
        if (o.illegal) ill_cnt++;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        clr = 1'b0;
        start = 1'b0;
        exp_q.delete();
        done_times.delete();
        read_cnt = 0;
        ill_cnt  = 0;
    endtask

    function automatic int done_lat(input int idx);
        if (done_times.size() > idx) return done_times[idx] - start_cyc;
        return -1;
    endfunction

    localparam logic [31:0] IR_AND = 32'h4A92_0000;   // and R5,R2,R4
    localparam logic [31:0] IR_SUB = {5'b00100, 4'd7, 4'd7, 4'd7, 15'd0};
    localparam logic [31:0] IR_SHL = {5'b01000, 4'd0, 4'd15, 4'd1, 15'd0};
    localparam logic [31:0] IR_BAD = {5'b11111, 4'd5, 4'd2, 4'd4, 15'd0};
    localparam logic [31:0] IR_R9  = {5'b01001, 4'd9, 4'd2, 4'd4, 15'd0};

    initial begin
        logic [31:0] irs [3];
        snap_t idle_s;
        idle_s = mk(3'd0, -1, -1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        irs[0] = IR_AND; irs[1] = IR_SUB; irs[2] = IR_SHL;
        clr = 1'b1; start = 1'b0; run = 1'b0; ir_in = IR_AND;

        // Reset held for two cycles, then idle with start low.
        tag = "reset";
        repeat (2) begin
            @(posedge Clock);
            @(negedge Clock);
            chk_snap("reset_dut0", o0, idle_s);
            chk_snap("reset_dutw", o1, idle_s);
            chk_snap("reset_dutn", o2, idle_s);
        end
        clr = 1'b0;
        tag = "idle";
        repeat (3) cyc();

        // AND R5,R2,R4, with a stray start pulse in T2 that must be ignored.
        do_reset();
        sel = 0; tag = "and"; ir_in = IR_AND;
        start = 1'b1; start_cyc = cycle; push_instr(IR_AND, 0, 16);
        cyc(); start = 1'b0;
        cyc(); cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        repeat (4) cyc();
        chk_int("and_done_latency", done_lat(0), 6);
        chk_int("and_done_count", done_times.size(), 1);

        // Memory wait states.
        do_reset();
        sel = 1; tag = "wait"; ir_in = IR_AND;
        start = 1'b1; start_cyc = cycle; push_instr(IR_AND, 3, 16);
        cyc(); start = 1'b0;
        repeat (10) cyc();
        chk_int("wait_read_cycles", read_cnt, 4);
        chk_int("wait_done_latency", done_lat(0), 9);

        // Illegal opcode with run high: abort in T3, back to IDLE.
        do_reset();
        sel = 0; tag = "ill_op"; ir_in = IR_BAD; run = 1'b1;
        start = 1'b1; push_instr(IR_BAD, 0, 16);
        cyc(); start = 1'b0;
        repeat (6) cyc();
        chk_int("ill_op_pulses", ill_cnt, 1);
        chk_int("ill_op_no_done", done_times.size(), 0);

        // Out-of-range destination register on the 8-register build.
        do_reset();
        sel = 2; tag = "ill_ra"; ir_in = IR_R9; run = 1'b1;
        start = 1'b1; push_instr(IR_R9, 0, 8);
        cyc(); start = 1'b0;
        repeat (6) cyc();
        chk_int("ill_ra_pulses", ill_cnt, 1);
        chk_int("ill_ra_no_done", done_times.size(), 0);

        // Continuous run: three back-to-back instructions, with run dropped during the third.
        do_reset();
        sel = 0; tag = "run"; run = 1'b1; ir_in = irs[0];
        start = 1'b1; start_cyc = cycle; push_instr(irs[0], 0, 16);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 6; j++) begin
                cyc();
                if (j == 0) begin
                    start = 1'b0;
                    ir_in = irs[i];
                    if (i < 2) push_instr(irs[i+1], 0, 16);
                    else       run = 1'b0;
                end
            end
        end
        repeat (2) cyc();
        chk_int("run_done_count", done_times.size(), 3);
        chk_int("run_first_latency", done_lat(0), 6);
        chk_int("run_gap1", done_lat(1) - done_lat(0), 6);
        chk_int("run_gap2", done_lat(2) - done_lat(1), 6);

        // Reset asserted mid-instruction during T4, then a clean restart.
        do_reset();
        sel = 0; tag = "midclr"; ir_in = IR_AND;
        start = 1'b1; push_instr(IR_AND, 0, 16);
        cyc(); start = 1'b0;
        repeat (4) cyc();
        #2 clr = 1'b1;
        #1 chk_snap("midclr_async", o0, idle_s);
        exp_q.delete();
        @(negedge Clock);
        clr = 1'b0;
        repeat (3) cyc();
        done_times.delete();
        tag = "restart";
        start = 1'b1; start_cyc = cycle; push_instr(IR_AND, 0, 16);
        cyc(); start = 1'b0;
        repeat (6) cyc();
        chk_int("restart_done_latency", done_lat(0), 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_step_sequencer.md
# alu_step_sequencer

Hardwired control-step sequencer for the datapath's three-register ALU instructions, replacing hand-driven testbench state machines. Each instruction runs as a fixed T0–T5 sequence: fetch, decode, operate, write back. The block drives the datapath's one-hot bus-out select vector, the register-enable vector, `ALU_Sel`, `IncPC` and `Read`. It extends the original flow with parametrised register count, control-bit positions, memory wait states, a continuous-run mode and illegal-instruction abort.

## Interface
Parameters:
- `NUM_REGS`, 16: implemented general registers; legal range 2..16.
- `CTRL_W`, 32: width of `bus_sel` and `reg_enable`.
- `ALU_SEL_W`, 5: width of `ALU_Sel`.
- `ALU_IDLE`, 7: `ALU_Sel` value whenever the sequencer is not in T4.
- `MEM_WAIT`, 0: extra T1 cycles, 0..15.
- `PC_BIT` 20, `IR_BIT` 21, `MDR_BIT` 22, `MAR_BIT` 23, `Y_BIT` 24, `ZLO_BIT` 19: control-bit positions.
  - In `reg_enable`, each bit is the matching "in" strobe.
  - In `bus_sel`, each bit is the matching "out" strobe.
  - General register n uses bit n in both vectors.

Ports:
- `Clock` in 1: rising-edge clock.
- `clr` in 1: asynchronous, active-high reset.
- `start` in 1: begin one instruction; sampled in IDLE only.
- `run` in 1: when 1, T5 goes directly to T0 (continuous execution).
- `IR_data_out` in 32: IR contents, decoded during T3–T5.
- `bus_sel` out `CTRL_W`: one-hot bus driver select (all zero = no driver).
- `reg_enable` out `CTRL_W`: register load enables.
- `ALU_Sel` out `ALU_SEL_W`: ALU operation.
- `IncPC` out 1: PC increment strobe.
- `Read` out 1: memory read into MDR.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse in T5.
- `illegal` out 1: one-cycle pulse on abort.
- `step` out 3: current state encoding.
  - IDLE = 0, T0 = 1 … T5 = 6.

## Operation
IR fields:
- opcode = [31:27]
- Ra = [26:23]
- Rb = [22:19]
- Rc = [18:15]

Opcode-to-`ALU_Sel` map:
- 00011 → 0 (add)
- 00100 → 1 (sub)
- 01001 → 3 (and)
- 01010 → 4 (or)
- 00111 → 5 (shr)
- 01000 → 6 (shl)
- Every other opcode is illegal.

All outputs are Moore-decoded from the state register, except fields decoded from `IR_data_out` in T3–T5. Each state asserts the following; everything not listed is 0 and `ALU_Sel` = `ALU_IDLE`:
- IDLE: nothing asserted.
- T0: `bus_sel[PC_BIT]`, `reg_enable[MAR_BIT]`, `IncPC`.
- T1: `Read`, `reg_enable[MDR_BIT]`.
  - Held for `MEM_WAIT`+1 cycles, counted by an internal wait counter that clears on T1 entry.
- T2: `bus_sel[MDR_BIT]`, `reg_enable[IR_BIT]`.
- T3: `bus_sel[Rb]`, `reg_enable[Y_BIT]`.
- T4: `bus_sel[Rc]`, `ALU_Sel` = mapped opcode, `reg_enable[ZLO_BIT]`.
- T5: `bus_sel[ZLO_BIT]`, `reg_enable[Ra]`, `done`.

Transitions:
- IDLE → T0 when `start` = 1.
- T0 → T1.
- T1 → T2 when the wait count reaches `MEM_WAIT`.
- T2 → T3.
- T3 → T4, or abort (see legality).
- T4 → T5.
- T5 → T0 if `run` = 1, else IDLE.

Legality check, evaluated in T3:
- A register index is illegal if it is ≥ `NUM_REGS`; this applies to Ra, Rb and Rc.
- An opcode is illegal if it is not in the map.
- On any illegality, T3 drives `illegal` = 1 instead of its normal outputs: all vectors 0, `Y_BIT` not loaded.
- The next state is then IDLE regardless of `run`.
- No general register is written for an aborted instruction.

Further rules:
- `start` outside IDLE is ignored.
- `run` is sampled only in T5.
- Ra = Rb = Rc is legal; the same register is used as source and destination.
- R0 is an ordinary register.

## Timing
- Reset: async `clr` forces IDLE within the same cycle.
  - All vectors and strobes are 0, `ALU_Sel` = `ALU_IDLE`, `step` = 0, wait counter 0.
  - This holds even mid-instruction; a partially completed instruction is abandoned with no T5 write.
- Latency: `start` sampled high at edge k gives T0 in cycle k+1 and `done` in cycle k+6+`MEM_WAIT`.
- Continuous mode: one instruction per 6+`MEM_WAIT` cycles, no IDLE bubble.
- `IR_data_out` must reflect the IR loaded at the end of T2 from T3 onward; the datapath's registered IR guarantees this.
- All outputs are glitch-free per cycle (registered state, combinational decode). Only one `bus_sel` bit is ever high.

## Test plan
- Reset/idle: assert `clr` for 2 cycles.
  - Required: all outputs 0, `ALU_Sel` = 7, `step` = 0.
  - With `start` = 0 the block stays in IDLE.
- AND R5,R2,R4: IR = 0x4A920000, `MEM_WAIT` = 0, `start` pulse.
  - T3: `bus_sel` = bit 2 with `reg_enable[24]`.
  - T4: `bus_sel` = bit 4 with `ALU_Sel` = 3 and `reg_enable[19]`.
  - T5: `reg_enable[5]`, `done` = 1 exactly 6 cycles after `start`, then IDLE.
- Wait states: `MEM_WAIT` = 3.
  - Required: `Read` high for exactly 4 consecutive cycles and `done` 9 cycles after `start`.
- Illegal abort: opcode 11111, and separately `NUM_REGS` = 8 with Ra = 9.
  - Required: `illegal` pulses in T3, no `reg_enable` bit set in T3–T5 window, return to IDLE even with `run` = 1.
- Continuous run: `run` = 1 for three instructions.
  - Required: T0 immediately follows T5, three `done` pulses 6 cycles apart.
- Mid-instruction reset: assert `clr` during T4.
  - Required: outputs clear asynchronously, `reg_enable[Ra]` never asserted, restart after `start` runs a full sequence.
